// File: rtl/bcd2bin_pkg.sv
// Shared constants, state encoding and input-validity helper for the BCD-to-binary converter.
package bcd2bin_pkg;

  localparam int unsigned NDIG = 3;   // BCD digits per conversion
  localparam int unsigned BW   = 10;  // binary result width
  localparam int unsigned ITER = 10;  // shift/adjust iterations, one per result bit

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // True when any packed 4-bit digit holds a non-decimal value (> 9).
  function automatic logic digits_invalid(input logic [4*NDIG-1:0] code);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (code[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit correction for reverse double-dabble: a digit that reads >= 8 after the
// right shift received a carried-in 10 (shown as 8), so 3 is taken off to restore 5.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd8) ? (din - 4'd3) : din;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential 3-digit BCD to binary converter. One shift/adjust iteration per cycle;
// non-decimal input digits short-circuit straight to DONE with err set.
module bcd2bin_seq #(
  parameter int unsigned NDIG = bcd2bin_pkg::NDIG,
  parameter int unsigned BW   = bcd2bin_pkg::BW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd,
  output logic              busy,
  output logic              done,
  output logic [BW-1:0]     bin,
  output logic              err
);

  import bcd2bin_pkg::*;

  // Working register: BCD digits on top, binary result assembling in the low BW bits.
  localparam int unsigned WW = 4 * NDIG + BW;

  state_e        state_q, state_d;
  logic [WW-1:0] work_q, work_d;
  logic [WW-1:0] work_sh, work_adj;
  logic [3:0]    cnt_q, cnt_d;
  logic [BW-1:0] bin_q, bin_d;
  logic          err_q, err_d;
  logic          in_bad;

  assign in_bad  = digits_invalid(bcd);
  assign work_sh = work_q >> 1;

  // Binary part is only shifted; each BCD digit field gets its own correction.
  assign work_adj[BW-1:0] = work_sh[BW-1:0];

  for (genvar i = 0; i < NDIG; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (work_sh[BW+4*i +: 4]),
      .dout (work_adj[BW+4*i +: 4])
    );
  end

  // Next-state, working-register and result update logic.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          work_d = {bcd, {BW{1'b0}}};
          cnt_d  = 4'd0;
          if (in_bad) begin
            state_d = StDone;
            bin_d   = '0;
            err_d   = 1'b1;
          end else begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        work_d = work_adj;
        if (cnt_q == 4'(ITER - 1)) begin
          state_d = StDone;
          cnt_d   = 4'd0;
          bin_d   = work_adj[BW-1:0];
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // All state, with asynchronous clear; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      work_q  <= '0;
      cnt_q   <= 4'd0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);
  assign bin  = bin_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Scoreboard bench for bcd2bin_seq: driver pushes model results, monitor pops on done.
module tb_bcd2bin_seq;

  typedef struct {
    logic       err;
    logic [9:0] bin;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [11:0] bcd;
  logic       busy;
  logic       done;
  logic [9:0] bin;
  logic       err;

  int   n_tests;
  int   n_fail;
  int   n_done;
  exp_t exp_q[$];

  bcd2bin_seq #(
    .NDIG (3),
    .BW   (10)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .bcd     (bcd),
    .busy    (busy),
    .done    (done),
    .bin     (bin),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal value of the three digits, or error if any digit is not decimal.
  function automatic exp_t model(input logic [11:0] code);
    exp_t r;
    int   h, t, u;
    h = int'(code[11:8]);
    t = int'(code[7:4]);
    u = int'(code[3:0]);
    if (h > 9 || t > 9 || u > 9) begin
      r.err = 1'b1;
      r.bin = 10'd0;
    end else begin
      r.err = 1'b0;
      r.bin = 10'(h * 100 + t * 10 + u);
    end
    return r;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got bin=%0d err=%0b, required no done", bin, err);
      end else begin
        e = exp_q.pop_front();
        check("sb_bin", int'(bin), int'(e.bin));
        check("sb_err", int'(err), int'(e.err));
      end
    end
  end

  // One conversion; optionally pulse start again at negedge poke_at (must be ignored).
  task automatic convert(input logic [11:0] code, input int poke_at, input logic [11:0] poke,
                         input bit full);
    exp_t e;
    int   k, nbusy;
    bit   seen;
    e = model(code);
    @(negedge clk);
    start = 1'b1;
    bcd   = code;
    exp_q.push_back(e);
    k = 0;
    nbusy = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (poke_at != 0 && k == poke_at) begin
        start = 1'b1;
        bcd   = poke;
      end else begin
        start = 1'b0;
        if (k == 1) bcd = 12'($urandom);
      end
      if (busy) nbusy++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done in %0d cycles, required done", k);
      exp_q.delete();
    end
    if (full || !seen) begin
      check("latency", k, e.err ? 1 : 11);
      check("busy_cycles", nbusy, e.err ? 0 : 10);
    end
    @(negedge clk);
    start = 1'b0;
    if (full) begin
      check("done_one_cycle", int'(done), 0);
      check("bin_hold", int'(bin), int'(e.bin));
      check("err_hold", int'(err), int'(e.err));
    end
  endtask

  initial begin
    logic [11:0] c;
    int          nd0;
    n_tests = 0;
    n_fail  = 0;
    n_done  = 0;
    reset_n = 1'b0;
    start   = 1'b0;
    bcd     = 12'h000;
    #1;
    check("reset_outputs", int'({busy, done, bin, err}), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", int'({busy, done}), 0);

    convert(12'h999, 0, 12'h000, 1'b1);
    convert(12'h000, 0, 12'h000, 1'b1);
    convert(12'h255, 0, 12'h000, 1'b1);
    convert(12'h1A3, 0, 12'h000, 1'b1);
    // Start during SHIFT, then during DONE: both must be ignored.
    convert(12'h512, 5, 12'h007, 1'b1);
    convert(12'h007, 0, 12'h000, 1'b1);
    convert(12'h384, 11, 12'h111, 1'b0);
    check("no_queued_start", int'({busy, done}), 0);

    // Abort mid-conversion with reset: everything clears and no done follows.
    @(negedge clk);
    start = 1'b1;
    bcd   = 12'h876;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    nd0 = n_done;
    reset_n = 1'b0;
    #1;
    check("abort_outputs", int'({busy, done, bin, err}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    check("no_done_after_abort", n_done, nd0);
    convert(12'h876, 0, 12'h000, 1'b1);

    // Sweep every valid code.
    for (int v = 0; v < 1000; v++) begin
      c = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      convert(c, 0, 12'h000, 1'b0);
    end

    // Random invalid codes: at least one nibble forced above 9.
    for (int i = 0; i < 40; i++) begin
      int p;
      c = 12'($urandom);
      p = int'($urandom_range(0, 2));
      c[4*p +: 4] = 4'($urandom_range(10, 15));
      convert(c, 0, 12'h000, 1'b0);
    end

    // Random mix of valid and invalid codes.
    for (int i = 0; i < 60; i++) begin
      convert(12'($urandom), 0, 12'h000, 1'b1);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcd2bin_seq.md
BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, named and ordered as below.
REQ-002 SHALL expose parameter: NDIG, default 3, number of BCD digits (fixed at 3 for this release).
REQ-003 SHALL expose parameter: BW, default 10, binary result width.
REQ-004 port: clk  input  1  rising-edge clock.
REQ-005 port: reset_n  input  1  asynchronous active-low reset.
REQ-006 port: start  input  1  conversion request, sampled only in IDLE.
REQ-007 port: bcd  input  12  three packed BCD digits, [11:8] hundreds, [7:4] tens, [3:0] units; sampled with start.
REQ-008 port: busy  output  1  high while a conversion is in progress (SHIFT state).
REQ-009 port: done  output  1  one-cycle pulse; bin and err valid while high and held afterwards.
REQ-010 port: bin  output  10  unsigned binary result, 0..999.
REQ-011 port: err  output  1  set when any input digit exceeded 9.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on start with all digits valid; IDLE->DONE on start with any digit > 9; SHIFT->DONE after the 10th iteration; DONE->IDLE unconditionally.
REQ-013 SHALL, on an accepted start (edge 0), load a 22-bit working register as {bcd, 10'b0}, clear the iteration counter, and capture err = (any digit > 9).
REQ-014 SHALL perform one reverse double-dabble iteration per SHIFT cycle: shift the working register right 1 bit, then subtract 3 from each 4-bit BCD digit field whose value is >= 8.
REQ-015 SHALL run exactly 10 iterations (edges 1..10); done SHALL be high in the cycle after edge 10; valid-input latency is 10 cycles from the start edge to done.
REQ-016 SHALL, on invalid input, skip SHIFT, set err=1, set bin=0, and pulse done in the cycle after edge 0.
REQ-017 SHALL update bin (low 10 bits of the working register) and err only on entry to DONE; both hold until the next DONE.
REQ-018 SHALL assert busy only in SHIFT; done only in DONE, for exactly one cycle.
REQ-019 SHALL ignore start in SHIFT and DONE, with no queuing; start held high continuously restarts a conversion on every IDLE cycle.
REQ-020 SHALL treat bcd as don't-care except on the accepted start edge; later changes do not affect the result.
REQ-021 SHALL keep the 4-bit iteration counter saturating-free: it counts 0..9 and is cleared on load.

Reset
REQ-022 SHALL, when reset_n is low, force state=IDLE, busy=0, done=0, bin=0, err=0, counter=0, and working register=0, asynchronously.
REQ-023 SHALL abort a mid-conversion on reset assertion; no done pulse SHALL follow, and the first start after release SHALL behave as from power-up.

Structure
REQ-024 SHALL place the state enum (IDLE, SHIFT, DONE), NDIG, BW, and ITER=10 constants in a shared package bcd2bin_pkg.
REQ-025 SHALL use one combinational sub-module, bcd_digit_adj (4-bit in/out: value >= 8 ? value-3 : value), instantiated once per digit.
REQ-026 SHALL contain all sequential logic in a single always_ff block with asynchronous reset, using no latches.

Verification
REQ-027 start, bcd=12'h999 -> done after 10 cycles, bin=10'd999 (0x3E7), err=0, busy high for exactly 10 cycles.
REQ-028 start, bcd=12'h000 -> bin=0, err=0, done after 10 cycles; then start, bcd=12'h255 -> bin=10'd255.
REQ-029 start, bcd=12'h1A3 -> done after 1 cycle, err=1, bin=0, busy never high.
REQ-030 start at edge 0 with 12'h512, then start with 12'h007 at cycle 5 -> the second start is ignored, bin=10'd512 at done, then a fresh start with 12'h007 gives 7.
REQ-031 reset_n pulsed low at cycle 6 of a 12'h876 conversion -> all outputs 0 immediately, no done; next start with 12'h876 -> bin=10'd876 at cycle 10.
REQ-032 exhaustive sweep of all 1000 valid codes -> bin matches the decimal value, err=0; a random sample of invalid codes -> err=1, bin=0.
